v810_mem_if: RTL and testbench
==============================

// Module: v810_mem_if
// PURPOSE
// - V810 bus control unit: merges instruction-fetch and data requests from the execution unit into one external bus.
// - Bus cycles are BCYSTn/DAn/READYn framed, with dynamic 16-bit bus sizing via SZRQn.
// - Sits between v810_exec (EU* ports) and the system memory decode (ROM/RAM/IO).
// PARAMETERS
// - none
// PORTS
// CLK     in  1  system clock
// RESn    in  1  reset; one clock; reset is synchronous and active-low
// CE      in  1  clock enable; all state advances only on CLK edges with CE=1
// EUIA    in  32 instruction fetch address (bits [1:0] ignored)
// EUID    out 32 fetched instruction word
// EUIREQ  in  1  fetch request (level, held until EUIACK)
// EUIACK  out 1  fetch done, 1 CE cycle pulse
// EUDA    in  32 data address
// EUDD_I  out 32 read data to EU, lane-aligned (not shifted)
// EUDD_O  in  32 write data from EU, lane-aligned
// EUDBC   in  2  size: 00 byte, 01 halfword, 10 word
// EUDBE   in  4  byte enables, active high, lane-aligned
// EUDWR   in  1  1=write, 0=read
// EUDMRQ  in  1  1=memory space, 0=I/O space
// EUDST   in  2  bus status for data access
// EUDREQ  in  1  data request (level, held until EUDACK)
// EUDACK  out 1  data done, 1 CE cycle pulse
// A       out 32 bus address
// D_I     in  32 bus read data
// D_O     out 32 bus write data
// BEn     out 4  byte enables, active low
// ST      out 2  status: 00 fetch, else EUDST
// DAn     out 1  data strobe, active low
// MRQn    out 1  memory request, active low (high = I/O)
// RW      out 1  1=read, 0=write
// BCYSTn  out 1  bus cycle start, active low, first cycle only
// READYn  in  1  cycle end, active low, sampled in T2
// SZRQn   in  1  low = 16-bit device; sampled with READYn
// BEHAVIOUR
// - Reset: BCYSTn=1, DAn=1, MRQn=1, RW=1, BEn=4'hF, A=0, ST=00, D_O=0, EUIACK=EUDACK=0, EUID=EUDD_I=0, state IDLE.
//   Reset mid-cycle aborts it immediately; no ACK is issued.
// - FSM IDLE -> T1 -> T2 (waits) -> IDLE or T1. One CE cycle each for IDLE and T1.
// - IDLE/arbitration:
//   - Pending request starts T1; EUDREQ has priority over EUIREQ.
//   - A request whose ACK is being pulsed this cycle counts as not pending.
// - T1: BCYSTn=0, DAn=1. A/ST/MRQn/RW/BEn/D_O are driven from T1 and held through T2.
//   - Fetch: A={EUIA[31:2],2'b00}, ST=00, MRQn=0, RW=1, BEn=0000.
//   - Data: A=EUDA, ST=EUDST, MRQn=~EUDMRQ, RW=~EUDWR, BEn=~EUDBE, D_O=EUDD_O.
// - T2: BCYSTn=1, DAn=0. Stays in T2 while READYn=1 (unlimited wait states).
// - Completion at the CE edge sampling READYn=0:
//   - SZRQn=1 (32-bit device): read data = D_I.
//   - SZRQn=0 (16-bit device): D_I[15:0] goes to lanes [15:0] if A[1]=0, else lanes [31:16].
// - Second cycle: word access (fetch or EUDBC=10) with SZRQn=0 on the first half.
//   - Runs another T1/T2 immediately: A[1]=1, BEn=0011.
//   - Write data D_O={EUDD_O[31:16],EUDD_O[31:16]}; read D_I[15:0] -> lanes [31:16].
//   - Byte/halfword accesses never split.
// - Finish: after the final READYn, latch EUID or EUDD_I (held until next completion of the same type).
//   - Matching ACK is 1 for exactly the next CE cycle.
//   - Bus returns BCYSTn=1, DAn=1, MRQn=1.
//   - A and BEn are held; the new T1 may begin in that ACK cycle.
// - Write read-data lanes: unaffected (EUDD_I holds prior value).
// - CE=0: all outputs frozen, READYn/SZRQn ignored.
// TESTING
// - Fetch EUIA=FFF0_0004 from 32-bit device, READYn low at first T2, D_I=1234_5678
//   -> BCYSTn 1 cycle, ST=00, EUID=12345678, EUIACK 1 pulse.
// - Same fetch, SZRQn=0, D_I[15:0]=5678 then 1234
//   -> 2 bus cycles, A=FFF0_0004 then FFF0_0006, EUID=12345678.
// - Data word write EUDA=0000_0100, EUDD_O=AABB_CCDD, 2 wait states
//   -> RW=0, BEn=0000, D_O=AABBCCDD, DAn low 3 cycles, EUDACK after READYn.
// - EUIREQ and EUDREQ raised same cycle -> data cycle first, then fetch; each ACK pulses once.
// - I/O byte read EUDMRQ=0, EUDST=10, EUDBE=0100 -> MRQn=1, ST=10, BEn=1011, EUDD_I[23:16]=D_I[23:16].
// - RESn low during T2 -> next cycle BCYSTn=DAn=MRQn=1, no ACK; held request restarts after reset.

Source files
------------

// File: rtl/v810_mem_if_if.sv
// V810 bus control unit signal bundle: execution-unit request side plus external bus side.
// master = bus controller (v810_mem_if), slave = execution unit / memory system.
interface v810_mem_if_if;
    logic [31:0] EUIA;
    logic [31:0] EUID;
    logic        EUIREQ;
    logic        EUIACK;
    logic [31:0] EUDA;
    logic [31:0] EUDD_I;
    logic [31:0] EUDD_O;
    logic [1:0]  EUDBC;
    logic [3:0]  EUDBE;
    logic        EUDWR;
    logic        EUDMRQ;
    logic [1:0]  EUDST;
    logic        EUDREQ;
    logic        EUDACK;
    logic [31:0] A;
    logic [31:0] D_I;
    logic [31:0] D_O;
    logic [3:0]  BEn;
    logic [1:0]  ST;
    logic        DAn;
    logic        MRQn;
    logic        RW;
    logic        BCYSTn;
    logic        READYn;
    logic        SZRQn;

    modport master (
        input  EUIA, EUIREQ, EUDA, EUDD_O, EUDBC, EUDBE, EUDWR, EUDMRQ, EUDST, EUDREQ,
        input  D_I, READYn, SZRQn,
        output EUID, EUIACK, EUDD_I, EUDACK,
        output A, D_O, BEn, ST, DAn, MRQn, RW, BCYSTn
    );

    modport slave (
        output EUIA, EUIREQ, EUDA, EUDD_O, EUDBC, EUDBE, EUDWR, EUDMRQ, EUDST, EUDREQ,
        output D_I, READYn, SZRQn,
        input  EUID, EUIACK, EUDD_I, EUDACK,
        input  A, D_O, BEn, ST, DAn, MRQn, RW, BCYSTn
    );
endinterface

// File: rtl/v810_mem_if.sv
// V810 bus control unit: arbitrates fetch and data requests onto one BCYSTn/DAn/READYn bus,
// splitting word accesses into two halves when a 16-bit device answers with SZRQn low.
module v810_mem_if (
    input  logic           CLK,
    input  logic           RESn,
    input  logic           CE,
    v810_mem_if_if.master  mem
);
    typedef enum logic [1:0] {S_IDLE, S_T1, S_T2} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_start;
    logic        w_sel_data;
    logic        w_split;
    logic        w_done;
    logic        w_dpend;
    logic        w_ipend;
    logic [31:0] w_lane16;
    logic [31:0] w_rdata;

    logic [31:0] r_a;
    logic [31:0] r_do;
    logic [3:0]  r_ben;
    logic [1:0]  r_st;
    logic        r_mrqn;
    logic        r_rw;
    logic        r_iack;
    logic        r_dack;
    logic [31:0] r_euid;
    logic [31:0] r_eudd;
    logic [31:0] r_acc;
    logic        r_fetch;
    logic        r_word;
    logic        r_half2;

    // A request whose ACK is currently pulsing is already served.
    assign w_dpend = mem.EUDREQ & ~r_dack;
    assign w_ipend = mem.EUIREQ & ~r_iack;

    always_ff @(posedge CLK) begin
        if (!RESn) begin
            r_state <= S_IDLE;
        end else if (CE) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_sel_data = 1'b0;
        w_split    = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_dpend) begin
                    w_start    = 1'b1;
                    w_sel_data = 1'b1;
                    w_next     = S_T1;
                end else if (w_ipend) begin
                    w_start = 1'b1;
                    w_next  = S_T1;
                end
            end
            S_T1: w_next = S_T2;
            S_T2: begin
                if (!mem.READYn) begin
                    if (r_word && !mem.SZRQn && !r_half2) begin
                        w_split = 1'b1;
                        w_next  = S_T1;
                    end else begin
                        // Back-to-back start only for the other requester; the finishing one is acked next cycle.
                        w_done = 1'b1;
                        if (r_fetch ? w_dpend : w_ipend) begin
                            w_start    = 1'b1;
                            w_sel_data = r_fetch;
                            w_next     = S_T1;
                        end else begin
                            w_next = S_IDLE;
                        end
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // 16-bit device data lands on the lanes selected by A[1]; the second half is always the upper lanes.
    always_comb begin
        w_lane16 = r_acc;
        if (r_half2 || r_a[1]) begin
            w_lane16[31:16] = mem.D_I[15:0];
        end else begin
            w_lane16[15:0] = mem.D_I[15:0];
        end
        w_rdata = (r_half2 || !mem.SZRQn) ? w_lane16 : mem.D_I;
    end

    always_ff @(posedge CLK) begin
        if (!RESn) begin
            r_a     <= '0;
            r_do    <= '0;
            r_ben   <= '1;
            r_st    <= '0;
            r_mrqn  <= 1'b1;
            r_rw    <= 1'b1;
            r_iack  <= 1'b0;
            r_dack  <= 1'b0;
            r_euid  <= '0;
            r_eudd  <= '0;
            r_acc   <= '0;
            r_fetch <= 1'b0;
            r_word  <= 1'b0;
            r_half2 <= 1'b0;
        end else if (CE) begin
            r_iack <= 1'b0;
            r_dack <= 1'b0;
            if (w_done) begin
                if (r_fetch) begin
                    r_euid <= w_rdata;
                    r_iack <= 1'b1;
                end else begin
                    if (r_rw) begin
                        r_eudd <= w_rdata;
                    end
                    r_dack <= 1'b1;
                end
                r_mrqn <= 1'b1;
            end
            if (w_split) begin
                r_half2 <= 1'b1;
                r_a[1]  <= 1'b1;
                r_ben   <= 4'b0011;
                r_do    <= {r_do[31:16], r_do[31:16]};
                r_acc   <= w_rdata;
            end
            // A start in the same edge as a completion overrides the idle MRQn.
            if (w_start) begin
                r_fetch <= ~w_sel_data;
                r_half2 <= 1'b0;
                r_acc   <= '0;
                if (w_sel_data) begin
                    r_a    <= mem.EUDA;
                    r_st   <= mem.EUDST;
                    r_mrqn <= ~mem.EUDMRQ;
                    r_rw   <= ~mem.EUDWR;
                    r_ben  <= ~mem.EUDBE;
                    r_do   <= mem.EUDD_O;
                    r_word <= (mem.EUDBC == 2'b10);
                end else begin
                    r_a    <= mem.EUIA & 32'hFFFF_FFFC;
                    r_st   <= 2'b00;
                    r_mrqn <= 1'b0;
                    r_rw   <= 1'b1;
                    r_ben  <= '0;
                    r_word <= 1'b1;
                end
            end
        end
    end

    assign mem.BCYSTn = (r_state != S_T1);
    assign mem.DAn    = (r_state != S_T2);
    assign mem.A      = r_a;
    assign mem.D_O    = r_do;
    assign mem.BEn    = r_ben;
    assign mem.ST     = r_st;
    assign mem.MRQn   = r_mrqn;
    assign mem.RW     = r_rw;
    assign mem.EUID   = r_euid;
    assign mem.EUIACK = r_iack;
    assign mem.EUDD_I = r_eudd;
    assign mem.EUDACK = r_dack;
endmodule

// File: tb/tb_v810_mem_if.sv
// Directed bench for v810_mem_if: a transaction-level model predicts every bus cycle and ACK,
// a bus responder plays the memory device, and a per-cycle compare checks the DUT.
module tb_v810_mem_if;
    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  ben;
        logic [1:0]  st;
        logic        mrqn;
        logic        rw;
        logic        chk_do;
        logic [31:0] dout;
    } bc_t;

    logic clk = 1'b0;
    logic resn;
    logic ce;
    always #5 clk = ~clk;

    v810_mem_if_if bus ();

    v810_mem_if dut (
        .CLK  (clk),
        .RESn (resn),
        .CE   (ce),
        .mem  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_iack   = 0;
    int n_dack   = 0;
    int cyc_cnt  = 0;
    int dan_cnt  = 0;

    bc_t         exp_q[$];
    logic [31:0] exp_id_q[$];
    logic [31:0] exp_dd_q[$];
    logic [31:0] m_id_held;
    logic [31:0] m_dd_held;
    logic [31:0] m_dd_model;
    logic [31:0] t1_a;
    logic [31:0] t1_do;
    logic        t1_rw;

    int          cfg_waits;
    logic        cfg16;
    logic [31:0] cfg_data;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic issue_fetch(input logic [31:0] addr, input logic [31:0] data, input logic d16);
        bc_t c;
        c = '0;
        c.a = {addr[31:2], 2'b00};
        c.ben = 4'b0000;
        c.rw = 1'b1;
        exp_q.push_back(c);
        if (d16) begin
            c.a[1] = 1'b1;
            c.ben = 4'b0011;
            exp_q.push_back(c);
        end
        exp_id_q.push_back(data);
        bus.EUIA = addr;
        bus.EUIREQ = 1'b1;
    endtask

    task automatic issue_data(input logic [31:0] addr, input logic wr, input logic mrq,
                              input logic [1:0] st, input logic [1:0] dbc, input logic [3:0] be,
                              input logic [31:0] wdata, input logic d16, input logic [31:0] rdata);
        bc_t c;
        c.a = addr;
        c.ben = ~be;
        c.st = st;
        c.mrqn = ~mrq;
        c.rw = ~wr;
        c.chk_do = 1'b1;
        c.dout = wdata;
        exp_q.push_back(c);
        if (dbc == 2'b10 && d16) begin
            c.a = addr | 32'h2;
            c.ben = 4'b0011;
            c.dout = {wdata[31:16], wdata[31:16]};
            exp_q.push_back(c);
        end
        if (!wr) m_dd_model = rdata;
        exp_dd_q.push_back(m_dd_model);
        bus.EUDA = addr;
        bus.EUDWR = wr;
        bus.EUDMRQ = mrq;
        bus.EUDST = st;
        bus.EUDBC = dbc;
        bus.EUDBE = be;
        bus.EUDD_O = wdata;
        bus.EUDREQ = 1'b1;
    endtask

    task automatic wait_acks(input int ni, input int nd);
        int ti;
        int td;
        ti = n_iack + ni;
        td = n_dack + nd;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.EUIACK) bus.EUIREQ = 1'b0;
            if (bus.EUDACK) bus.EUDREQ = 1'b0;
            if (n_iack >= ti && n_dack >= td) break;
        end
        chk("ack_count", {n_iack, n_dack}, {ti, td});
        bus.EUIREQ = 1'b0;
        bus.EUDREQ = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Memory device: holds READYn high for cfg_waits T2 cycles, 16-bit devices return one half per cycle.
    task automatic responder();
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.SZRQn = ~cfg16;
            if (!bus.DAn) begin
                if (wcnt == cfg_waits) begin
                    bus.READYn = 1'b0;
                    bus.D_I = cfg16 ? {16'hBEEF, (bus.A[1] ? cfg_data[31:16] : cfg_data[15:0])} : cfg_data;
                end else begin
                    bus.READYn = 1'b1;
                end
                wcnt++;
            end else begin
                bus.READYn = 1'b1;
                bus.D_I = 32'h0BAD_F00D;
                wcnt = 0;
            end
        end
    endtask

    task automatic compare_loop();
        bc_t  cur;
        logic prev_i;
        logic prev_d;
        cur = '0;
        cur.ben = 4'hF;
        prev_i = 1'b0;
        prev_d = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!resn) begin
                chk("reset_state",
                    {bus.BCYSTn, bus.DAn, bus.MRQn, bus.RW, bus.BEn, bus.A, bus.ST, bus.D_O,
                     bus.EUIACK, bus.EUDACK, bus.EUID, bus.EUDD_I},
                    {4'b1111, 4'hF, 32'h0, 2'b00, 32'h0, 2'b00, 32'h0, 32'h0});
                exp_q.delete();
                exp_id_q.delete();
                exp_dd_q.delete();
                cur = '0;
                cur.ben = 4'hF;
                m_id_held = '0;
                m_dd_held = '0;
                m_dd_model = '0;
                prev_i = 1'b0;
                prev_d = 1'b0;
            end else begin
                if (!bus.BCYSTn) begin
                    cyc_cnt++;
                    t1_a = bus.A;
                    t1_do = bus.D_O;
                    t1_rw = bus.RW;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL cycle_expected actual=start A=%0h required=no cycle", bus.A);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("t1_fields", {bus.A, bus.BEn, bus.ST, bus.MRQn, bus.RW, bus.DAn},
                            {cur.a, cur.ben, cur.st, cur.mrqn, cur.rw, 1'b1});
                        if (cur.chk_do) chk("t1_dout", bus.D_O, cur.dout);
                    end
                end else if (!bus.DAn) begin
                    dan_cnt++;
                    chk("t2_hold", {bus.A, bus.BEn, bus.ST, bus.MRQn, bus.RW},
                        {cur.a, cur.ben, cur.st, cur.mrqn, cur.rw});
                end else begin
                    chk("idle_bus", {bus.MRQn, bus.A, bus.BEn}, {1'b1, cur.a, cur.ben});
                end
                if (bus.EUIACK) begin
                    n_iack++;
                    chk("iack_pulse", prev_i, 1'b0);
                    if (exp_id_q.size() > 0) m_id_held = exp_id_q.pop_front();
                    else begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL iack_expected actual=ack required=none");
                    end
                end
                if (bus.EUDACK) begin
                    n_dack++;
                    chk("dack_pulse", prev_d, 1'b0);
                    if (exp_dd_q.size() > 0) m_dd_held = exp_dd_q.pop_front();
                    else begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL dack_expected actual=ack required=none");
                    end
                end
                chk("euid", bus.EUID, m_id_held);
                chk("eudd_i", bus.EUDD_I, m_dd_held);
                prev_i = bus.EUIACK;
                prev_d = bus.EUDACK;
            end
        end
    endtask

    initial begin
        int c0;
        int d0;
        int a0;
        resn = 1'b0;
        ce = 1'b1;
        bus.EUIA = '0;   bus.EUIREQ = 1'b0;
        bus.EUDA = '0;   bus.EUDD_O = '0;  bus.EUDBC = '0;  bus.EUDBE = '0;
        bus.EUDWR = 1'b0; bus.EUDMRQ = 1'b0; bus.EUDST = '0; bus.EUDREQ = 1'b0;
        bus.D_I = '0;    bus.READYn = 1'b1; bus.SZRQn = 1'b1;
        cfg_waits = 0; cfg16 = 1'b0; cfg_data = '0;
        m_id_held = '0; m_dd_held = '0; m_dd_model = '0;
        t1_a = '0; t1_do = '0; t1_rw = 1'b1;
        fork
            compare_loop();
            responder();
        join_none
        repeat (2) @(negedge clk);
        resn = 1'b1;
        @(negedge clk);

        // Fetch from a 32-bit device, no wait states.
        cfg_waits = 0; cfg16 = 1'b0; cfg_data = 32'h1234_5678;
        c0 = cyc_cnt;
        issue_fetch(32'hFFF0_0004, 32'h1234_5678, 1'b0);
        wait_acks(1, 0);
        chk("fetch32_euid", m_id_held, 32'h1234_5678);
        chk("fetch32_cycles", cyc_cnt - c0, 1);

        // Same fetch from a 16-bit device splits into two bus cycles.
        cfg16 = 1'b1;
        c0 = cyc_cnt;
        issue_fetch(32'hFFF0_0004, 32'h1234_5678, 1'b1);
        wait_acks(1, 0);
        chk("fetch16_cycles", cyc_cnt - c0, 2);
        chk("fetch16_addr2", t1_a, 32'hFFF0_0006);

        // Word write, two wait states.
        cfg_waits = 2; cfg16 = 1'b0;
        d0 = dan_cnt;
        issue_data(32'h0000_0100, 1'b1, 1'b1, 2'b01, 2'b10, 4'hF, 32'hAABB_CCDD, 1'b0, '0);
        wait_acks(0, 1);
        chk("write_dan_cycles", dan_cnt - d0, 3);
        chk("write_t1", {t1_rw, t1_do}, {1'b0, 32'hAABB_CCDD});

        // Simultaneous requests: data cycle must win arbitration.
        cfg_waits = 1; cfg_data = 32'hCAFE_F00D;
        a0 = n_iack; d0 = n_dack;
        issue_data(32'h0000_0200, 1'b1, 1'b1, 2'b11, 2'b10, 4'hF, 32'h5566_7788, 1'b0, '0);
        issue_fetch(32'h0000_1000, 32'hCAFE_F00D, 1'b0);
        wait_acks(1, 1);
        chk("both_acks", {n_iack - a0, n_dack - d0}, {32'd1, 32'd1});
        chk("both_last_addr", t1_a, 32'h0000_1000);

        // I/O byte read on lane 2.
        cfg_waits = 0; cfg_data = 32'h11A5_2233;
        issue_data(32'h0000_0302, 1'b0, 1'b0, 2'b10, 2'b00, 4'b0100, 32'h0, 1'b0, 32'h11A5_2233);
        wait_acks(0, 1);
        chk("io_byte_lane", m_dd_held[23:16], 8'hA5);

        // Word read from a 16-bit device.
        cfg_waits = 1; cfg16 = 1'b1; cfg_data = 32'hDEAD_BEEF;
        c0 = cyc_cnt;
        issue_data(32'h0000_0400, 1'b0, 1'b1, 2'b01, 2'b10, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF);
        wait_acks(0, 1);
        chk("rd16_cycles", cyc_cnt - c0, 2);
        chk("rd16_data", m_dd_held, 32'hDEAD_BEEF);

        // Word write to a 16-bit device: upper half replicated on the second cycle; EUDD_I untouched.
        cfg_waits = 0;
        issue_data(32'h0000_0500, 1'b1, 1'b1, 2'b01, 2'b10, 4'hF, 32'h1122_3344, 1'b1, '0);
        wait_acks(0, 1);
        chk("wr16_do2", t1_do, 32'h1122_1122);
        chk("wr16_keep_rd", m_dd_held, 32'hDEAD_BEEF);

        // CE low freezes the controller while a request waits.
        cfg16 = 1'b0; cfg_data = 32'h0F0F_A5A5;
        ce = 1'b0;
        c0 = cyc_cnt;
        issue_fetch(32'h0000_2008, 32'h0F0F_A5A5, 1'b0);
        repeat (3) @(negedge clk);
        chk("ce_freeze", cyc_cnt - c0, 0);
        ce = 1'b1;
        wait_acks(1, 0);

        // Reset during T2 aborts without ACK; held request restarts afterwards.
        cfg_waits = 4; cfg_data = 32'h7654_3210;
        d0 = dan_cnt;
        a0 = n_iack;
        issue_fetch(32'h0000_3000, 32'h7654_3210, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dan_cnt > d0) break;
        end
        chk("reached_t2", dan_cnt > d0, 1'b1);
        resn = 1'b0;
        @(negedge clk);
        issue_fetch(32'h0000_3000, 32'h7654_3210, 1'b0);
        resn = 1'b1;
        wait_acks(1, 0);
        chk("reset_single_ack", n_iack - a0, 1);
        chk("reset_restart_euid", m_id_held, 32'h7654_3210);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
